imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the instruction memory in the single-cycle MIPS core. It receives a framed byte stream and assembles big-endian 32-bit words. It writes those words sequentially through the instruction memory write port. The CPU is held in reset until a complete, checksum-valid image has been stored.

---
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader in front of the instruction memory.
// Accepts a framed byte stream (0xA5, word count N, 4N big-endian data bytes,
// optional checksum byte) and writes each assembled word to sequential
// word-aligned addresses. The CPU stays in reset until an image completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the trailing checksum
// byte and its verification; without it the frame ends after the last data byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int         CW        = ADDR_WIDTH - 2;
  localparam int         MAX_WORDS = 2 ** CW;
  localparam logic [7:0] HDR       = 8'hA5;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHECK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t                  state_q, state_d;
  logic [23:0]             asm_q, asm_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]           word_cnt_q, word_cnt_d;
  logic [CW-1:0]           last_idx_q, last_idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif
  logic                    rx_ready_q, rx_ready_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]             imem_wdata_q, imem_wdata_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic                    len_bad;

  assign accept  = rx_valid && rx_ready_q;
  assign len_bad = (rx_data == 8'd0) || ({24'd0, rx_data} > 32'(MAX_WORDS));

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    last_idx_d   = last_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    error_d      = error_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        // Anything other than a header byte is dropped; a header restarts
        // parsing and clears a previous failure.
        if (accept && rx_data == HDR) begin
          state_d = S_LEN;
          error_d = 1'b0;
        end
      end

      S_LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            // Store N-1 so the terminal compare fits in the word counter.
            last_idx_d = CW'(rx_data - 8'd1);
            word_cnt_d = '0;
            byte_cnt_d = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d      = 8'd0;
`endif
            state_d    = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          asm_d      = {asm_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = {word_cnt_q, 2'b00};
            imem_wdata_d = {asm_q, rx_data};
            if (word_cnt_q == last_idx_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (8'(sum_q + rx_data) == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs follow the state being entered so they are registered
    // alongside it.
    rx_ready_d  = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    cpu_reset_d = (state_d != S_DONE);
  end

  // State and registered outputs; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      asm_q        <= '0;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= '0;
      last_idx_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= 8'd0;
`endif
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      last_idx_q   <= last_idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from random words, the
// expected writes and final status are derived from the frame contents, and a
// monitor compares every write strobe against the expected-write queue.
module tb_imem_loader;

  localparam int AW   = 8;
  localparam int MAXW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [7:0]  frame_q[$];
  logic [31:0] words[MAXW];
  int          n_checks = 0;
  int          n_fails  = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
        check("write_data", imem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},   32'(rx_ready),  32'd0);
    check({tag, "_imem_we"},    32'(imem_we),   32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,     32'd0);
    check({tag, "_cpu_reset"},  32'(cpu_reset), 32'd1);
    check({tag, "_done"},       32'(done),      32'd0);
    check({tag, "_error"},      32'(error),     32'd0);
  endtask

  // Offer one byte and hold it until accepted; optional idle cycle beforehand.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int w;
    w = 0;
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_fails++;
      $display("FAIL rx_ready_timeout: got rx_ready=%0b for 200 cycles, expected 1", rx_ready);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
  endtask

  // Frame bytes from the word list; the checksum makes the data-byte sum zero mod 256.
  task automatic build(input int len, input bit legal, input bit bad_ck);
    logic [7:0] s;
    s = 8'd0;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(len));
    if (legal) begin
      for (int i = 0; i < len; i++) begin
        for (int j = 3; j >= 0; j--) begin
          frame_q.push_back(words[i][8*j +: 8]);
          s = s + words[i][8*j +: 8];
        end
      end
      if (CK) frame_q.push_back(bad_ck ? 8'(8'd1 - s) : 8'(8'd0 - s));
    end
  endtask

  task automatic run_frame(input int len, input bit bad_ck, input bit toggle, input string tag);
    bit legal;
    bit ok;
    legal = (len >= 1) && (len <= MAXW);
    ok    = legal && !(CK && bad_ck);
    build(len, legal, bad_ck);
    if (legal)
      for (int i = 0; i < len; i++) exp_q.push_back('{addr: AW'(4 * i), data: words[i]});
    foreach (frame_q[i]) send_byte(frame_q[i], toggle);
    check({tag, "_done"},      32'(done),      32'(ok));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
    check({tag, "_error"},     32'(error),     32'(!ok));
    check({tag, "_rx_ready"},  32'(rx_ready),  32'(!ok));
    @(negedge clk); #1;
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();
    check_reset_vals("por");

    // Reference frame from the bring-up image.
    words[0] = 32'h20080005;
    words[1] = 32'h01094020;
    run_frame(2, 1'b0, 1'b0, "plan");

    // Corrupted checksum, then recovery with a valid frame.
    if (CK) begin
      do_reset();
      words[0] = 32'h20080005;
      words[1] = 32'h01094020;
      run_frame(2, 1'b1, 1'b0, "badck");
      rand_words(3);
      run_frame(3, 1'b0, 1'b0, "recover");
    end

    // Illegal lengths.
    do_reset();
    run_frame(0, 1'b0, 1'b0, "len00");
    do_reset();
    run_frame(65, 1'b0, 1'b0, "len41");

    // Junk before the header is ignored.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'hFF, 1'b0);
    check("junk_done",      32'(done),      32'd0);
    check("junk_error",     32'(error),     32'd0);
    check("junk_cpu_reset", 32'(cpu_reset), 32'd1);
    check("junk_rx_ready",  32'(rx_ready),  32'd1);
    words[0] = 32'h20080005;
    words[1] = 32'h01094020;
    run_frame(2, 1'b0, 1'b0, "postjunk");

    // Reset after six data bytes: only the first word is written.
    do_reset();
    rand_words(2);
    exp_q.push_back('{addr: AW'(0), data: words[0]});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int j = 3; j >= 0; j--) send_byte(words[0][8*j +: 8], 1'b0);
    for (int j = 3; j >= 2; j--) send_byte(words[1][8*j +: 8], 1'b0);
    do_reset();
    check_reset_vals("midrst");
    @(negedge clk); #1;
    check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    run_frame(2, 1'b0, 1'b0, "resend");

    // Full-capacity image with a bubble between every byte.
    do_reset();
    rand_words(MAXW);
    run_frame(MAXW, 1'b0, 1'b1, "full");

    // Random frames.
    for (int k = 0; k < 6; k++) begin
      int len;
      bit bad;
      do_reset();
      len = $urandom_range(1, 12);
      bad = CK && ($urandom_range(0, 2) == 0);
      rand_words(len);
      run_frame(len, bad, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
